// File: rtl/program_counter_ctrl_pkg.sv
// program_counter_ctrl_pkg: shared types and defaults for the instruction-fetch sequencer
package program_counter_ctrl_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int INSTR_W_DEF = 32;
  localparam logic [31:0] END_INSTR_DEF = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_READ = 2'd1,
    HALTED    = 2'd2
  } pc_state_e;
endpackage

// File: rtl/program_counter_ctrl.sv
// program_counter_ctrl: issues sequential instruction reads from address 0 until the end-of-program word
module program_counter_ctrl
  import program_counter_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] END_INSTR = INSTR_W'(END_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               reiniciar,
  input  logic               lectura_completada,
  input  logic [INSTR_W-1:0] instruccion_actual,
  output logic               leer_siguiente_inst,
  output logic [ADDR_W-1:0]  direccion_siguiente_inst
);
  pc_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic leer_q, leer_d;
  logic start, done, adv, fin;
  assign start = reiniciar | (state_q == IDLE & iniciar);
  assign done  = state_q == WAIT_READ & lectura_completada;
  assign fin   = instruccion_actual == END_INSTR;
  assign adv   = ~reiniciar & done & ~fin;
  // state, address and request registers; all outputs come straight from flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      leer_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      leer_q  <= leer_d;
    end
  end
  // next state: restart/start enter WAIT_READ, end-of-program word halts
  always_comb begin
    state_d = start ? WAIT_READ : (done & fin) ? HALTED : state_q;
  end
  // next outputs: request pulses on start or on each accepted non-final completion
  always_comb begin
    leer_d = start | adv;
    addr_d = start ? '0 : adv ? addr_q + ADDR_W'(1) : addr_q;
  end
  assign leer_siguiente_inst = leer_q;
  assign direccion_siguiente_inst = addr_q;
endmodule

// File: tb/tb_program_counter_ctrl.sv
// tb_program_counter_ctrl: scoreboard bench for the instruction-fetch sequencer
module tb_program_counter_ctrl;
  localparam logic [31:0] END_W = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic reset, iniciar, reiniciar, lectura_completada;
  logic [31:0] instruccion_actual;
  logic leer_siguiente_inst;
  logic [13:0] direccion_siguiente_inst;
  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  int m_st;
  logic [13:0] m_addr;
  logic m_leer;
  program_counter_ctrl dut (
    .clk(clk),
    .reset(reset),
    .iniciar(iniciar),
    .reiniciar(reiniciar),
    .lectura_completada(lectura_completada),
    .instruccion_actual(instruccion_actual),
    .leer_siguiente_inst(leer_siguiente_inst),
    .direccion_siguiente_inst(direccion_siguiente_inst)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic rst, input logic ini, input logic rei,
                     input logic lec, input logic [31:0] ins);
    logic [14:0] e;
    @(negedge clk);
    reset = rst;
    iniciar = ini;
    reiniciar = rei;
    lectura_completada = lec;
    instruccion_actual = ins;
    m_leer = 1'b0;
    if (rst) begin
      m_st = 0;
      m_addr = '0;
    end else if (rei || (m_st == 0 && ini)) begin
      m_st = 1;
      m_addr = '0;
      m_leer = 1'b1;
    end else if (m_st == 1 && lec) begin
      if (ins == END_W) m_st = 2;
      else begin
        m_addr = m_addr + 14'd1;
        m_leer = 1'b1;
      end
    end
    exp_q.push_back({m_leer, m_addr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, 32'({leer_siguiente_inst, direccion_siguiente_inst}), 32'(e));
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  initial begin
    m_st = 0;
    m_addr = '0;
    m_leer = 1'b0;
    reset = 1'b1;
    iniciar = 1'b0;
    reiniciar = 1'b0;
    lectura_completada = 1'b0;
    instruccion_actual = '0;
    cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("reset_leer", 32'(leer_siguiente_inst), 32'd0);
    check("reset_addr", 32'(direccion_siguiente_inst), 32'd0);
    idle("idle", 5);
    cyc("start", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("start_leer", 32'(leer_siguiente_inst), 32'd1);
    idle("start_wait", 3);
    for (int i = 0; i < 5; i++) begin
      cyc("fetch", 1'b0, 1'b0, 1'b0, 1'b1, 32'(i));
      check("fetch_addr", 32'(direccion_siguiente_inst), 32'(i + 1));
      idle("fetch_gap", 3);
    end
    cyc("end", 1'b0, 1'b0, 1'b0, 1'b1, END_W);
    idle("halted", 2);
    cyc("halt_lec", 1'b0, 1'b0, 1'b0, 1'b1, 32'd7);
    cyc("halt_ini", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    idle("halted2", 2);
    check("halt_addr", 32'(direccion_siguiente_inst), 32'd5);
    check("halt_leer", 32'(leer_siguiente_inst), 32'd0);
    cyc("restart_halt", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("restart_halt_addr", 32'(direccion_siguiente_inst), 32'd0);
    idle("rs_gap", 1);
    for (int i = 0; i < 3; i++) begin
      cyc("refetch", 1'b0, 1'b0, 1'b0, 1'b1, 32'(i));
      idle("refetch_gap", 1);
    end
    check("mid_addr", 32'(direccion_siguiente_inst), 32'd3);
    cyc("restart_mid", 1'b0, 1'b0, 1'b1, 1'b1, 32'd9);
    check("restart_mid_addr", 32'(direccion_siguiente_inst), 32'd0);
    check("restart_mid_leer", 32'(leer_siguiente_inst), 32'd1);
    for (int i = 0; i < 16383; i++) cyc("wrap_run", 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
    check("wrap_top", 32'(direccion_siguiente_inst), 32'd16383);
    cyc("wrap", 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
    check("wrap_zero", 32'(direccion_siguiente_inst), 32'd0);
    cyc("reset_mid", 1'b1, 1'b0, 1'b0, 1'b1, 32'd1);
    for (int i = 0; i < 3; i++) cyc("idle_lec", 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
    check("idle_lec_leer", 32'(leer_siguiente_inst), 32'd0);
    idle("tail", 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
